// File: rtl/eth_pkg.sv
// eth_pkg: shared Ethernet constants and the TX MAC state encoding.
// Used by the GMII transmit MAC and by the CRC-32 byte engine.
package eth_pkg;

    localparam logic [7:0]  ETH_PREAMBLE  = 8'h55;
    localparam logic [7:0]  ETH_SFD       = 8'hD5;
    localparam logic [31:0] ETH_CRC_POLY  = 32'hEDB88320;
    localparam logic [31:0] ETH_CRC_INIT  = 32'hFFFFFFFF;
    localparam int          ETH_MIN_FRAME = 60;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_SFD,
        ST_DATA,
        ST_PAD,
        ST_FCS,
        ST_DRAIN,
        ST_IFG
    } eth_tx_state_e;

endpackage

// File: rtl/eth_crc32_d8.sv
// eth_crc32_d8: combinational reflected CRC-32 update for one byte.
// The CRC state register lives in the instantiating module.
module eth_crc32_d8
    import eth_pkg::*;
(
    input  logic [31:0] crc,
    input  logic [7:0]  data,
    output logic [31:0] crc_next
);

    always_comb begin
        logic [31:0] c;
        c = crc ^ {24'h000000, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ ETH_CRC_POLY) : (c >> 1);
        end
        crc_next = c;
    end

endmodule

// File: rtl/eth_mac_tx_gmii.sv
// eth_mac_tx_gmii: byte-stream to GMII TX MAC (preamble, pad, FCS, IFG).
// Define ETH_MAC_TX_STATS_EN to add tx_frame_cnt / tx_oversize_cnt.
module eth_mac_tx_gmii
    import eth_pkg::*;
#(
    parameter int IFG_CYCLES = 12,
    parameter int MIN_FRAME  = ETH_MIN_FRAME,
    parameter int MAX_FRAME  = 9100,
    parameter int CNT_W      = 14
) (
    input  logic        eth_tx_clk,
    input  logic        eth_tx_rst_n,
    input  logic [7:0]  eth_tx_data,
    input  logic        eth_tx_data_en,
    output logic        eth_tx_ack,
`ifdef ETH_MAC_TX_STATS_EN
    output logic [31:0] tx_frame_cnt,
    output logic [15:0] tx_oversize_cnt,
`endif
    output logic [7:0]  gmii_txd,
    output logic        gmii_tx_en,
    output logic        gmii_tx_er
);

    localparam int IFG_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES + 1) : 1;

    localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_FRAME);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_FRAME);
    localparam logic [IFG_W-1:0] IFG_END = IFG_W'(IFG_CYCLES - 1);

    eth_tx_state_e    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      crc_q, crc_d;
    logic [31:0]      crc_nxt;
    logic [7:0]       crc_in;
    logic [2:0]       pcnt_q, pcnt_d;
    logic [2:0]       fidx_q, fidx_d;
    logic [IFG_W-1:0] icnt_q, icnt_d;
    logic [7:0]       txd_d;
    logic             en_d;
    logic             er_d;
    logic             ack_d;
    logic             frame_done;
    logic             oversize;

    // Pad bytes are zero, so only live payload feeds a non-zero byte.
    assign crc_in = ((state_q == ST_SFD || state_q == ST_DATA) && eth_tx_data_en)
                  ? eth_tx_data : 8'h00;

    eth_crc32_d8 u_crc (
        .crc      (crc_q),
        .data     (crc_in),
        .crc_next (crc_nxt)
    );

    always_ff @(posedge eth_tx_clk or negedge eth_tx_rst_n) begin
        if (!eth_tx_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        crc_d      = crc_q;
        pcnt_d     = pcnt_q;
        fidx_d     = fidx_q;
        icnt_d     = icnt_q;
        txd_d      = 8'h00;
        en_d       = 1'b0;
        er_d       = 1'b0;
        ack_d      = 1'b0;
        frame_done = 1'b0;
        oversize   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (eth_tx_data_en) begin
                    state_d = ST_PRE;
                    pcnt_d  = 3'd1;
                    en_d    = 1'b1;
                    txd_d   = ETH_PREAMBLE;
                end
            end

            ST_PRE: begin
                en_d = 1'b1;
                if (pcnt_q == 3'd7) begin
                    state_d = ST_SFD;
                    txd_d   = ETH_SFD;
                    cnt_d   = '0;
                    crc_d   = ETH_CRC_INIT;
                end else begin
                    txd_d  = ETH_PREAMBLE;
                    pcnt_d = pcnt_q + 3'd1;
                    ack_d  = (pcnt_q == 3'd6);
                end
            end

            ST_SFD, ST_DATA: begin
                en_d = 1'b1;
                if (eth_tx_data_en) begin
                    if (cnt_q == MAX_CNT) begin
                        state_d  = ST_DRAIN;
                        er_d     = 1'b1;
                        oversize = 1'b1;
                    end else begin
                        state_d = ST_DATA;
                        txd_d   = eth_tx_data;
                        crc_d   = crc_nxt;
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end else if (cnt_q < MIN_CNT) begin
                    state_d = ST_PAD;
                    crc_d   = crc_nxt;
                    cnt_d   = cnt_q + CNT_W'(1);
                end else begin
                    state_d = ST_FCS;
                    txd_d   = ~crc_q[7:0];
                    fidx_d  = 3'd1;
                end
            end

            ST_PAD: begin
                en_d = 1'b1;
                if (cnt_q < MIN_CNT) begin
                    crc_d = crc_nxt;
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    state_d = ST_FCS;
                    txd_d   = ~crc_q[7:0];
                    fidx_d  = 3'd1;
                end
            end

            ST_FCS: begin
                if (fidx_q == 3'd4) begin
                    state_d = ST_IFG;
                    icnt_d  = '0;
                    cnt_d   = '0;
                end else begin
                    en_d       = 1'b1;
                    txd_d      = ~crc_q[{fidx_q[1:0], 3'b000} +: 8];
                    fidx_d     = fidx_q + 3'd1;
                    frame_done = (fidx_q == 3'd3);
                end
            end

            ST_DRAIN: begin
                if (!eth_tx_data_en) begin
                    state_d = ST_IFG;
                    icnt_d  = '0;
                    cnt_d   = '0;
                end
            end

            ST_IFG: begin
                cnt_d = '0;
                if (icnt_q == IFG_END) begin
                    state_d = ST_IDLE;
                end else begin
                    icnt_d = icnt_q + IFG_W'(1);
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge eth_tx_clk or negedge eth_tx_rst_n) begin
        if (!eth_tx_rst_n) begin
            cnt_q      <= '0;
            crc_q      <= ETH_CRC_INIT;
            pcnt_q     <= '0;
            fidx_q     <= '0;
            icnt_q     <= '0;
            gmii_txd   <= 8'h00;
            gmii_tx_en <= 1'b0;
            gmii_tx_er <= 1'b0;
            eth_tx_ack <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            crc_q      <= crc_d;
            pcnt_q     <= pcnt_d;
            fidx_q     <= fidx_d;
            icnt_q     <= icnt_d;
            gmii_txd   <= txd_d;
            gmii_tx_en <= en_d;
            gmii_tx_er <= er_d;
            eth_tx_ack <= ack_d;
        end
    end

`ifdef ETH_MAC_TX_STATS_EN
    always_ff @(posedge eth_tx_clk or negedge eth_tx_rst_n) begin
        if (!eth_tx_rst_n) begin
            tx_frame_cnt    <= '0;
            tx_oversize_cnt <= '0;
        end else begin
            if (frame_done) begin
                tx_frame_cnt <= tx_frame_cnt + 32'd1;
            end
            if (oversize) begin
                tx_oversize_cnt <= tx_oversize_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
